// File: rtl/his_builder_multi_pkg.sv
// Shared types and default sizing for the dToF histogram builder.
package his_builder_multi_pkg;

    localparam int unsigned DEF_ADDR_W       = 10;
    localparam int unsigned DEF_COUNT_W      = 16;
    localparam int unsigned DEF_ACQ_W        = 16;
    localparam int unsigned DEF_COARSE_SHIFT = 3;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_ACQ,
        ST_DRAIN,
        ST_READ
    } state_t;

endpackage

// File: rtl/his_builder_multi_bin_ram.sv
// Histogram bin storage: simple dual-port synchronous RAM, read-first on address collision.
module his_bin_ram #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/his_builder_multi.sv
// dToF histogram builder: RMW accumulation of TDC hits over N laser cycles, then
// valid/ready readout that zeroes each bin as it is accepted.
module his_builder_multi
    import his_builder_multi_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned COUNT_W      = DEF_COUNT_W,
    parameter int unsigned ACQ_W        = DEF_ACQ_W,
    parameter int unsigned COARSE_SHIFT = DEF_COARSE_SHIFT
) (
    input  logic               clk,
    input  logic               res,
    input  logic               hit_valid,
    input  logic [ADDR_W-1:0]  addr,
    input  logic               laser_tick,
    input  logic               coarse_mode,
    input  logic [ACQ_W-1:0]   cfg_acq_cycles,
    input  logic               bin_ready,
    output logic               bin_valid,
    output logic [ADDR_W-1:0]  bin_idx,
    output logic [COUNT_W-1:0] bin_count,
    output logic               data_finish,
    output logic               his_num,
    output logic               hit_dropped
);

    localparam int unsigned       NBINS       = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_FINE   = ADDR_W'(NBINS - 1);
    localparam logic [ADDR_W-1:0] LAST_COARSE = ADDR_W'((NBINS >> COARSE_SHIFT) - 1);

    state_t state, state_nxt;

    logic [ADDR_W-1:0]  clr_ptr;
    logic               drain_cnt;
    logic [ACQ_W-1:0]   tick_cnt;
    logic [ACQ_W-1:0]   acq_last;
    logic               mode;
    logic               acq_enter;
    logic [ADDR_W-1:0]  nlast;

    logic               s0_valid, s1_valid, s2_valid;
    logic [ADDR_W-1:0]  s0_idx, s1_idx, s2_idx;
    logic [COUNT_W-1:0] s2_count;
    logic [COUNT_W-1:0] s1_src, s1_new;
    logic [ADDR_W-1:0]  hit_idx;

    logic [ADDR_W:0]    rd_ptr;
    logic               p1_valid;
    logic [ADDR_W-1:0]  p1_idx;
    logic               issue, accept, out_adv, p1_adv;

    logic               ram_we, ram_re;
    logic [ADDR_W-1:0]  ram_waddr, ram_raddr;
    logic [COUNT_W-1:0] ram_wdata, ram_rdata;

    his_bin_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (COUNT_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign nlast     = mode ? LAST_COARSE : LAST_FINE;
    assign hit_idx   = mode ? (addr >> COARSE_SHIFT) : addr;
    assign acq_enter = (state_nxt == ST_ACQ) && (state != ST_ACQ);

    // The write lands at the S1->S2 edge, so only the value still sitting in S2
    // can be missing from a read-first RAM result.
    assign s1_src = (s2_valid && (s2_idx == s1_idx)) ? s2_count : ram_rdata;
    assign s1_new = (&s1_src) ? s1_src : s1_src + 1'b1;

    assign issue   = (state == ST_READ) && (rd_ptr <= {1'b0, nlast});
    assign accept  = bin_valid && bin_ready;
    assign out_adv = !bin_valid || bin_ready;
    assign p1_adv  = !p1_valid || out_adv;

    always_comb begin
        ram_we    = s1_valid;
        ram_waddr = s1_idx;
        ram_wdata = s1_new;
        ram_re    = 1'b1;
        ram_raddr = s0_idx;
        case (state)
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_ptr;
                ram_wdata = '0;
            end
            ST_READ: begin
                ram_we    = accept;
                ram_waddr = bin_idx;
                ram_wdata = '0;
                ram_re    = p1_adv;
                ram_raddr = rd_ptr[ADDR_W-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        data_finish = 1'b0;
        case (state)
            ST_CLEAR: begin
                if (clr_ptr == LAST_FINE) begin
                    state_nxt = ST_ACQ;
                end
            end
            ST_ACQ: begin
                if (laser_tick && (tick_cnt == acq_last)) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt) begin
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                if (accept && (bin_idx == nlast)) begin
                    data_finish = 1'b1;
                    state_nxt   = ST_ACQ;
                end
            end
            default: state_nxt = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            clr_ptr     <= '0;
            drain_cnt   <= 1'b0;
            tick_cnt    <= '0;
            acq_last    <= '0;
            mode        <= 1'b0;
            s0_valid    <= 1'b0;
            s0_idx      <= '0;
            s1_valid    <= 1'b0;
            s1_idx      <= '0;
            s2_valid    <= 1'b0;
            s2_idx      <= '0;
            s2_count    <= '0;
            rd_ptr      <= '0;
            p1_valid    <= 1'b0;
            p1_idx      <= '0;
            bin_valid   <= 1'b0;
            bin_idx     <= '0;
            bin_count   <= '0;
            his_num     <= 1'b0;
            hit_dropped <= 1'b0;
        end else begin
            s0_valid    <= hit_valid && (state == ST_ACQ);
            s0_idx      <= hit_idx;
            s1_valid    <= s0_valid;
            s1_idx      <= s0_idx;
            s2_valid    <= s1_valid;
            if (s1_valid) begin
                s2_idx   <= s1_idx;
                s2_count <= s1_new;
            end
            hit_dropped <= hit_valid && (state != ST_ACQ);

            if (state == ST_CLEAR) begin
                clr_ptr <= clr_ptr + 1'b1;
            end
            drain_cnt <= (state == ST_DRAIN) ? !drain_cnt : 1'b0;

            if (acq_enter) begin
                mode     <= coarse_mode;
                acq_last <= (cfg_acq_cycles == '0) ? '0 : cfg_acq_cycles - 1'b1;
                tick_cnt <= '0;
            end else if ((state == ST_ACQ) && laser_tick) begin
                tick_cnt <= tick_cnt + 1'b1;
            end

            // Two-stage readout: RAM output (p1) then output register; the RAM
            // read enable follows p1_adv so the RAM itself holds data during a stall.
            if (state != ST_READ) begin
                rd_ptr    <= '0;
                p1_valid  <= 1'b0;
                bin_valid <= 1'b0;
            end else begin
                if (p1_adv) begin
                    p1_valid <= issue;
                    p1_idx   <= rd_ptr[ADDR_W-1:0];
                    if (issue) begin
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                end
                if (out_adv) begin
                    bin_valid <= p1_valid;
                    bin_idx   <= p1_idx;
                    bin_count <= p1_valid ? ram_rdata : '0;
                end
            end

            if (data_finish) begin
                his_num <= !his_num;
            end
        end
    end

endmodule

// File: tb/tb_his_builder_multi.sv
// Directed bench for his_builder_multi: fine/coarse histograms, saturation, backpressure, reset.
module tb_his_builder_multi;

    logic        clk = 1'b0;
    logic        res;
    logic        hit_valid;
    logic [9:0]  addr;
    logic        laser_tick;
    logic        coarse_mode;
    logic [15:0] cfg_acq_cycles;
    logic        bin_ready;
    logic        bin_valid;
    logic [9:0]  bin_idx;
    logic [15:0] bin_count;
    logic        data_finish;
    logic        his_num;
    logic        hit_dropped;

    logic        s_res;
    logic        s_hit_valid;
    logic [3:0]  s_addr;
    logic        s_laser_tick;
    logic        s_bin_ready;
    logic        s_bin_valid;
    logic [3:0]  s_bin_idx;
    logic [3:0]  s_bin_count;
    logic        s_data_finish;
    logic        s_his_num;
    logic        s_hit_dropped;

    int errors = 0;
    int checks = 0;

    int unsigned got [0:1023];
    int n_beats, ord_err, hold_err, fin_seen, fin_idx, timeout;

    always #5 clk = ~clk;

    his_builder_multi dut (
        .clk            (clk),
        .res            (res),
        .hit_valid      (hit_valid),
        .addr           (addr),
        .laser_tick     (laser_tick),
        .coarse_mode    (coarse_mode),
        .cfg_acq_cycles (cfg_acq_cycles),
        .bin_ready      (bin_ready),
        .bin_valid      (bin_valid),
        .bin_idx        (bin_idx),
        .bin_count      (bin_count),
        .data_finish    (data_finish),
        .his_num        (his_num),
        .hit_dropped    (hit_dropped)
    );

    his_builder_multi #(
        .ADDR_W       (4),
        .COUNT_W      (4),
        .ACQ_W        (16),
        .COARSE_SHIFT (3)
    ) dut_sat (
        .clk            (clk),
        .res            (s_res),
        .hit_valid      (s_hit_valid),
        .addr           (s_addr),
        .laser_tick     (s_laser_tick),
        .coarse_mode    (1'b0),
        .cfg_acq_cycles (16'd1),
        .bin_ready      (s_bin_ready),
        .bin_valid      (s_bin_valid),
        .bin_idx        (s_bin_idx),
        .bin_count      (s_bin_count),
        .data_finish    (s_data_finish),
        .his_num        (s_his_num),
        .hit_dropped    (s_hit_dropped)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_hit(input logic [9:0] a, input logic tick, inout int drops);
        hit_valid  = 1'b1;
        addr       = a;
        laser_tick = tick;
        step();
        hit_valid  = 1'b0;
        laser_tick = 1'b0;
        if (hit_dropped) drops++;
    endtask

    // Streams one histogram; stops just before the edge that accepts the data_finish bin.
    task automatic collect(input bit toggle, input int budget);
        logic        prev_stall;
        logic [9:0]  prev_idx;
        logic [15:0] prev_cnt;
        n_beats = 0; ord_err = 0; hold_err = 0; fin_seen = 0; fin_idx = -1; timeout = 1;
        prev_stall = 1'b0; prev_idx = '0; prev_cnt = '0;
        for (int i = 0; i < 1024; i++) got[i] = 0;
        bin_ready = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            bin_ready = toggle ? ~bin_ready : 1'b1;
            #1;
            if (prev_stall && (!bin_valid || bin_idx !== prev_idx || bin_count !== prev_cnt))
                hold_err++;
            if (bin_valid && bin_ready) begin
                if (bin_idx != 10'(n_beats)) ord_err++;
                if (n_beats < 1024) got[n_beats] = bin_count;
                if (data_finish) begin
                    fin_seen++;
                    fin_idx = bin_idx;
                end
                n_beats++;
            end else if (data_finish) begin
                fin_seen++;
            end
            prev_stall = bin_valid && !bin_ready;
            prev_idx   = bin_idx;
            prev_cnt   = bin_count;
            if (bin_valid && bin_ready && data_finish) begin
                timeout = 0;
                break;
            end
        end
        bin_ready = 1'b1;
    endtask

    task automatic test_reset();
        res = 1'b0; s_res = 1'b0;
        hit_valid = 1'b0; addr = '0; laser_tick = 1'b0; coarse_mode = 1'b0;
        cfg_acq_cycles = 16'd1; bin_ready = 1'b1;
        s_hit_valid = 1'b0; s_addr = '0; s_laser_tick = 1'b0; s_bin_ready = 1'b1;
        repeat (3) step();
        checks++;
        if ({bin_valid, data_finish, his_num, hit_dropped} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0000", {bin_valid, data_finish, his_num, hit_dropped});
        end
        checks++;
        if (bin_count !== 16'd0 || bin_idx !== 10'd0) begin
            errors++;
            $display("FAIL reset_bin: idx=%0d count=%0d want 0/0", bin_idx, bin_count);
        end
        res = 1'b1; s_res = 1'b1;
    endtask

    task automatic test_clear();
        int vcount = 0;
        repeat (10) step();
        hit_valid = 1'b1; addr = 10'd3;
        step();
        hit_valid = 1'b0;
        checks++;
        if (hit_dropped !== 1'b1) begin
            errors++;
            $display("FAIL clear_drop: hit_dropped=%b want 1", hit_dropped);
        end
        step();
        checks++;
        if (hit_dropped !== 1'b0) begin
            errors++;
            $display("FAIL clear_drop_pulse: hit_dropped=%b want 0", hit_dropped);
        end
        for (int c = 0; c < 1090; c++) begin
            step();
            if (bin_valid) vcount++;
        end
        checks++;
        if (vcount != 0) begin
            errors++;
            $display("FAIL clear_idle_valid: bin_valid cycles=%0d want 0", vcount);
        end
    endtask

    task automatic test_fine();
        int drops = 0;
        int nz = 0;
        drive_hit(10'd5, 1'b0, drops);
        drive_hit(10'd5, 1'b0, drops);
        drive_hit(10'd5, 1'b0, drops);
        drive_hit(10'd9, 1'b1, drops);
        coarse_mode = 1'b1;
        cfg_acq_cycles = 16'd2;
        checks++;
        if (drops != 0) begin
            errors++;
            $display("FAIL fine_acq_drop: dropped=%0d want 0", drops);
        end
        checks++;
        if (his_num !== 1'b0) begin
            errors++;
            $display("FAIL fine_hisnum_before: got %b want 0", his_num);
        end
        collect(1'b0, 3000);
        for (int i = 0; i < 1024; i++) if (i != 5 && i != 9 && got[i] != 0) nz++;
        checks++;
        if (timeout != 0 || n_beats != 1024 || ord_err != 0) begin
            errors++;
            $display("FAIL fine_stream: beats=%0d order_err=%0d timeout=%0d want 1024/0/0", n_beats, ord_err, timeout);
        end
        checks++;
        if (got[5] != 3 || got[9] != 1) begin
            errors++;
            $display("FAIL fine_bins: bin5=%0d bin9=%0d want 3/1", got[5], got[9]);
        end
        checks++;
        if (nz != 0) begin
            errors++;
            $display("FAIL fine_zero_bins: nonzero=%0d want 0", nz);
        end
        checks++;
        if (fin_seen != 1 || fin_idx != 1023) begin
            errors++;
            $display("FAIL fine_finish: seen=%0d idx=%0d want 1/1023", fin_seen, fin_idx);
        end
        step();
        checks++;
        if (his_num !== 1'b1 || data_finish !== 1'b0) begin
            errors++;
            $display("FAIL fine_hisnum_after: his_num=%b finish=%b want 1/0", his_num, data_finish);
        end
    endtask

    task automatic test_coarse();
        int drops = 0;
        int nz = 0;
        for (int a = 8; a < 16; a++) drive_hit(10'(a), (a == 8 || a == 15), drops);
        coarse_mode = 1'b0;
        cfg_acq_cycles = 16'd1;
        collect(1'b0, 500);
        for (int i = 0; i < 128; i++) if (i != 1 && got[i] != 0) nz++;
        checks++;
        if (timeout != 0 || n_beats != 128 || ord_err != 0) begin
            errors++;
            $display("FAIL coarse_stream: beats=%0d order_err=%0d timeout=%0d want 128/0/0", n_beats, ord_err, timeout);
        end
        checks++;
        if (got[1] != 8 || nz != 0) begin
            errors++;
            $display("FAIL coarse_bins: bin1=%0d nonzero_others=%0d want 8/0", got[1], nz);
        end
        checks++;
        if (fin_idx != 127 || drops != 0) begin
            errors++;
            $display("FAIL coarse_finish: idx=%0d drops=%0d want 127/0", fin_idx, drops);
        end
        step();
        checks++;
        if (his_num !== 1'b0) begin
            errors++;
            $display("FAIL coarse_hisnum: got %b want 0", his_num);
        end
    endtask

    task automatic test_back_to_back();
        int drops = 0;
        int nz = 0;
        drive_hit(10'd0, 1'b0, drops);
        drive_hit(10'd1023, 1'b0, drops);
        drive_hit(10'd700, 1'b0, drops);
        drive_hit(10'd1023, 1'b1, drops);
        collect(1'b1, 5000);
        for (int i = 1; i < 1023; i++) if (i != 700 && got[i] != 0) nz++;
        checks++;
        if (timeout != 0 || n_beats != 1024 || ord_err != 0 || hold_err != 0) begin
            errors++;
            $display("FAIL bp_stream: beats=%0d order_err=%0d hold_err=%0d timeout=%0d want 1024/0/0/0", n_beats, ord_err, hold_err, timeout);
        end
        checks++;
        if (got[0] != 1 || got[700] != 1 || got[1023] != 2 || nz != 0) begin
            errors++;
            $display("FAIL bp_bins: b0=%0d b700=%0d b1023=%0d nz=%0d want 1/1/2/0", got[0], got[700], got[1023], nz);
        end
        step();
        laser_tick = 1'b1;
        step();
        laser_tick = 1'b0;
        hit_valid = 1'b1; addr = 10'd44;
        step();
        hit_valid = 1'b0;
        checks++;
        if (hit_dropped !== 1'b1) begin
            errors++;
            $display("FAIL drain_drop: hit_dropped=%b want 1", hit_dropped);
        end
        collect(1'b0, 2000);
        nz = 0;
        for (int i = 0; i < 1024; i++) if (got[i] != 0) nz++;
        checks++;
        if (timeout != 0 || n_beats != 1024 || nz != 0 || fin_idx != 1023) begin
            errors++;
            $display("FAIL second_hist_zero: beats=%0d nonzero=%0d fin=%0d want 1024/0/1023", n_beats, nz, fin_idx);
        end
        step();
    endtask

    task automatic test_reset_mid_read();
        int bad = 0;
        laser_tick = 1'b1;
        step();
        laser_tick = 1'b0;
        repeat (8) step();
        checks++;
        if (bin_valid !== 1'b1) begin
            errors++;
            $display("FAIL midread_streaming: bin_valid=%b want 1", bin_valid);
        end
        res = 1'b0;
        step();
        checks++;
        if ({bin_valid, data_finish, his_num, hit_dropped} !== 4'b0000 || bin_count !== 16'd0) begin
            errors++;
            $display("FAIL midread_reset: flags=%b count=%0d want 0000/0", {bin_valid, data_finish, his_num, hit_dropped}, bin_count);
        end
        res = 1'b1;
        for (int c = 0; c < 30; c++) begin
            step();
            if (bin_valid || data_finish || his_num) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midread_after: active cycles=%0d want 0", bad);
        end
    endtask

    task automatic test_saturation();
        int beats = 0;
        int nz = 0;
        int fin = 0;
        int b2 = -1;
        for (int h = 0; h < 20; h++) begin
            s_hit_valid = 1'b1; s_addr = 4'd2; s_laser_tick = (h == 19);
            step();
        end
        s_hit_valid = 1'b0; s_laser_tick = 1'b0;
        for (int c = 0; c < 100 && fin == 0; c++) begin
            step();
            if (s_bin_valid && s_bin_ready) begin
                if (s_bin_idx == 4'd2) b2 = s_bin_count;
                else if (s_bin_count != 4'd0) nz++;
                if (s_data_finish) fin = 1;
                beats++;
            end
        end
        checks++;
        if (b2 != 15) begin
            errors++;
            $display("FAIL sat_bin2: got %0d want 15", b2);
        end
        checks++;
        if (beats != 16 || nz != 0 || fin != 1) begin
            errors++;
            $display("FAIL sat_stream: beats=%0d nonzero=%0d finish=%0d want 16/0/1", beats, nz, fin);
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_fine();
        test_coarse();
        test_back_to_back();
        test_reset_mid_read();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
